arbiter_rr2: RTL

Two-requester round-robin arbiter with registered grants and a bounded grant-hold time. It drives the `gnt_0`/`gnt_1` pair that the arbiter assertion checker monitors, taking `req_0`/`req_1` directly from the two bus masters. The block guarantees by construction the properties the checker enforces:
- Grants are mutually exclusive.
- Every grant is backed by a request sampled on the previous clock edge.

---
 rtl/arbiter_rr2.sv | 119 +++++++++++
 1 files changed

// File: rtl/arbiter_rr2.sv
// Two-requester round-robin arbiter with registered grants, a bounded
// grant-hold time under contention and a pulse flagging forced hand-overs.
module arbiter_rr2 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1,
    output logic preempt
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                w_last_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_nxt;
    logic                r_gnt_0;
    logic                r_gnt_1;
    logic                r_preempt;
    logic                w_gnt_0_nxt;
    logic                w_gnt_1_nxt;
    logic                w_preempt_nxt;
    logic                w_force;
    logic                w_hold_sat;

    assign w_hold_sat = (r_hold_cnt == HOLD_MAX);

    // State, pointer, hold counter and output flops; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
            r_gnt_0    <= 1'b0;
            r_gnt_1    <= 1'b0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gnt_0    <= w_gnt_0_nxt;
            r_gnt_1    <= w_gnt_1_nxt;
            r_preempt  <= w_preempt_nxt;
        end
    end

    // Next-state selection; w_force marks a hand-over caused by the hold limit.
    always_comb begin
        w_state_nxt = r_state;
        w_force     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_0 && req_1) begin
                    w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
                end else if (req_0) begin
                    w_state_nxt = ST_GNT0;
                end else if (req_1) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!req_0) begin
                    w_state_nxt = req_1 ? ST_GNT1 : ST_IDLE;
                end else if (req_1 && w_hold_sat) begin
                    w_state_nxt = ST_GNT1;
                    w_force     = 1'b1;
                end
            end
            ST_GNT1: begin
                if (!req_1) begin
                    w_state_nxt = req_0 ? ST_GNT0 : ST_IDLE;
                end else if (req_0 && w_hold_sat) begin
                    w_state_nxt = ST_GNT0;
                    w_force     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Values loaded into the output, pointer and counter flops at the next edge.
    always_comb begin
        w_gnt_0_nxt    = (w_state_nxt == ST_GNT0);
        w_gnt_1_nxt    = (w_state_nxt == ST_GNT1);
        w_preempt_nxt  = w_force;
        w_last_nxt     = r_last;
        w_hold_cnt_nxt = r_hold_cnt;
        if (w_state_nxt == ST_GNT0 && r_state != ST_GNT0) begin
            w_last_nxt = 1'b0;
        end else if (w_state_nxt == ST_GNT1 && r_state != ST_GNT1) begin
            w_last_nxt = 1'b1;
        end
        if (w_state_nxt == ST_IDLE || w_state_nxt != r_state) begin
            w_hold_cnt_nxt = '0;
        end else if (!w_hold_sat) begin
            w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
    end

    assign gnt_0   = r_gnt_0;
    assign gnt_1   = r_gnt_1;
    assign preempt = r_preempt;

endmodule
